// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory fetch bus: one-outstanding req/gnt/rvalid handshake.
//   req    : fetch request valid (driven by the fetch unit)
//   addr   : fetch word address (driven by the fetch unit)
//   gnt    : memory accepted the request this cycle
//   rvalid : response data valid (earliest one cycle after gnt)
//   rdata  : instruction word returned by memory
// Modports: master = fetch unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch front end. Owns the architectural PC, fetches one word at
// a time from instruction memory and holds it until decode consumes it.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   next_pc_i      : redirect target from next-PC selection
//   redirect_i     : load next_pc_i into the PC this cycle
//   stall_i        : decode cannot accept the held instruction
//   imem           : fetch bus (master side)
//   pc_o, pc_add_o : current PC and PC+4 (wrapping)
//   inst_o         : held instruction (NOP after reset)
//   inst_valid_o   : inst_o is valid for pc_o
//   misalign_o     : instruction-address-misaligned fault held
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            next_pc_i,
    input  logic                   redirect_i,
    input  logic                   stall_i,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            pc_o,
    output logic [31:0]            pc_add_o,
    output logic [31:0]            inst_o,
    output logic                   inst_valid_o,
    output logic                   misalign_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_FAULT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;

    // A response is still owed to us after this edge: either the memory is
    // granting right now, or an earlier grant has not been answered yet.
    logic        resp_owed;
    logic        target_misaligned;
    logic        pc_misaligned;

    assign resp_owed = ((state_q == S_REQ) && imem.gnt) ||
                       (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem.rvalid);
    assign target_misaligned = (next_pc_i[1:0] != 2'b00);
    // While draining, pc_q already holds the redirect target, so its
    // alignment decides whether the drain ends in FAULT or a new fetch.
    assign pc_misaligned     = (pc_q[1:0] != 2'b00);

    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem.gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.rvalid) begin
                    inst_d  = imem.rdata;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem.rvalid) begin
                    state_d = pc_misaligned ? S_FAULT : S_REQ;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Redirect overrides everything above; any response arriving in the
        // same cycle belongs to the abandoned path and is dropped.
        if (redirect_i) begin
            pc_d    = next_pc_i;
            inst_d  = inst_q;
            valid_d = 1'b0;
            if (resp_owed) begin
                state_d = S_DRAIN;
            end else begin
                state_d = target_misaligned ? S_FAULT : S_REQ;
            end
        end

        req_d      = (state_d == S_REQ);
        misalign_d = (state_d == S_FAULT);
        if (state_d == S_FAULT) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            inst_q     <= NOP;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem.req     = req_q;
    assign imem.addr    = pc_q;
    assign pc_o         = pc_q;
    assign pc_add_o     = pc_q + 32'd4;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;
    assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed scenarios for reset, stall, redirect, drain, misalignment and
// wrap, followed by a randomized run against a transaction-level model:
// the model tracks only the architectural PC, the outstanding memory
// request and what instruction word belongs at each address.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic        redirect;
    logic        stall;
    logic [31:0] pc_o;
    logic [31:0] pc_add_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        misalign_o;

    int total = 0;
    int bad   = 0;

    if_fetch_unit_if imem ();

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .next_pc_i    (next_pc),
        .redirect_i   (redirect),
        .stall_i      (stall),
        .imem         (imem),
        .pc_o         (pc_o),
        .pc_add_o     (pc_add_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk = ~clk;

    // Outputs are sampled and inputs changed 1 time unit after each edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory contents used by the randomized run: a fixed scramble of the address.
    function automatic logic [31:0] inst_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Grant immediately, respond one cycle later with the given word.
    task automatic fetch_word(input logic [31:0] data);
        imem.gnt    = 1'b1;
        step();
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b1;
        imem.rdata  = data;
        step();
        imem.rvalid = 1'b0;
        imem.rdata  = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; stall = 1'b0; next_pc = 32'h0;
        imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'h0;
        step(); step();
        total++; if (pc_o !== RESET_PC) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc_o, RESET_PC); end
        total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", imem.req); end
        total++; if (inst_o !== NOP) begin bad++; $display("FAIL reset_inst got=%h want=%h", inst_o, NOP); end
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", inst_valid_o); end
        total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b want=0", misalign_o); end
        rst = 1'b0;
        step();
        total++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin bad++; $display("FAIL first_req got=%b/%h want=1/0", imem.req, imem.addr); end
        imem.gnt = 1'b1;
        step();
        imem.gnt = 1'b0;
        total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL wait_req got=%b want=0", imem.req); end
        imem.rvalid = 1'b1; imem.rdata = 32'h0050_0093;
        step();
        imem.rvalid = 1'b0; imem.rdata = 32'h0;
        total++; if (inst_valid_o !== 1'b1) begin bad++; $display("FAIL first_valid got=%b want=1", inst_valid_o); end
        total++; if (inst_o !== 32'h0050_0093) begin bad++; $display("FAIL first_inst got=%h want=00500093", inst_o); end
        total++; if (pc_o !== 32'h0 || pc_add_o !== 32'h4) begin bad++; $display("FAIL first_pc got=%h/%h want=0/4", pc_o, pc_add_o); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (inst_valid_o !== 1'b1 || inst_o !== 32'h0050_0093 || pc_o !== 32'h0 || imem.req !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold got=v%b i%h p%h r%b want=v1 i00500093 p0 r0", inst_valid_o, inst_o, pc_o, imem.req);
            end
        end
        stall = 1'b0;
        step();
        total++; if (inst_valid_o !== 1'b0 || imem.req !== 1'b1 || imem.addr !== 32'h4) begin bad++; $display("FAIL stall_release got=v%b r%b a%h want=v0 r1 a4", inst_valid_o, imem.req, imem.addr); end
        fetch_word(32'h00A0_0113);
        total++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h00A0_0113 || pc_o !== 32'h4) begin bad++; $display("FAIL second_inst got=v%b i%h p%h want=v1 i00a00113 p4", inst_valid_o, inst_o, pc_o); end
        step();
        total++; if (imem.req !== 1'b1 || imem.addr !== 32'h8) begin bad++; $display("FAIL third_addr got=r%b a%h want=r1 a8", imem.req, imem.addr); end
        fetch_word(32'h1234_5678);
    endtask

    task automatic test_redirect_hold();
        next_pc = 32'h0000_0100; redirect = 1'b1;
        step();
        redirect = 1'b0;
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL redir_hold_valid got=%b want=0", inst_valid_o); end
        total++; if (imem.req !== 1'b1 || imem.addr !== 32'h100 || pc_add_o !== 32'h104) begin bad++; $display("FAIL redir_hold_addr got=r%b a%h +%h want=r1 a100 +104", imem.req, imem.addr, pc_add_o); end
    endtask

    task automatic test_redirect_wait();
        imem.gnt = 1'b1;
        step();
        imem.gnt = 1'b0;
        next_pc = 32'h0000_0300; redirect = 1'b1;
        step();
        redirect = 1'b0;
        total++; if (imem.req !== 1'b0 || pc_o !== 32'h300 || inst_valid_o !== 1'b0) begin bad++; $display("FAIL drain_enter got=r%b p%h v%b want=r0 p300 v0", imem.req, pc_o, inst_valid_o); end
        step();
        total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL drain_wait_req got=%b want=0", imem.req); end
        imem.rvalid = 1'b1; imem.rdata = 32'hDEAD_BEEF;
        step();
        imem.rvalid = 1'b0; imem.rdata = 32'h0;
        total++; if (imem.req !== 1'b1 || imem.addr !== 32'h300 || inst_valid_o !== 1'b0) begin bad++; $display("FAIL drain_exit got=r%b a%h v%b want=r1 a300 v0", imem.req, imem.addr, inst_valid_o); end
        total++; if (inst_o !== 32'h1234_5678) begin bad++; $display("FAIL stale_inst got=%h want=12345678", inst_o); end
        fetch_word(32'h0F0F_0F0F);
        total++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0F0F_0F0F || pc_o !== 32'h300) begin bad++; $display("FAIL after_drain got=v%b i%h p%h want=v1 i0f0f0f0f p300", inst_valid_o, inst_o, pc_o); end
    endtask

    task automatic test_misalign();
        next_pc = 32'h0000_0102; redirect = 1'b1;
        step();
        redirect = 1'b0;
        total++; if (misalign_o !== 1'b1 || imem.req !== 1'b0 || inst_valid_o !== 1'b0 || pc_o !== 32'h102) begin bad++; $display("FAIL fault_enter got=m%b r%b v%b p%h want=m1 r0 v0 p102", misalign_o, imem.req, inst_valid_o, pc_o); end
        for (int i = 0; i < 4; i++) begin
            stall = 1'($urandom_range(0, 1));
            step();
            total++; if (misalign_o !== 1'b1 || imem.req !== 1'b0) begin bad++; $display("FAIL fault_stay got=m%b r%b want=m1 r0", misalign_o, imem.req); end
        end
        stall = 1'b0;
        next_pc = 32'h0000_0200; redirect = 1'b1;
        step();
        redirect = 1'b0;
        total++; if (misalign_o !== 1'b0 || imem.req !== 1'b1 || imem.addr !== 32'h200) begin bad++; $display("FAIL fault_exit got=m%b r%b a%h want=m0 r1 a200", misalign_o, imem.req, imem.addr); end
        // Misaligned redirect while a grant is taken: drain first, then fault.
        imem.gnt = 1'b1; next_pc = 32'h0000_0206; redirect = 1'b1;
        step();
        imem.gnt = 1'b0; redirect = 1'b0;
        total++; if (misalign_o !== 1'b0 || imem.req !== 1'b0 || pc_o !== 32'h206) begin bad++; $display("FAIL mis_drain got=m%b r%b p%h want=m0 r0 p206", misalign_o, imem.req, pc_o); end
        imem.rvalid = 1'b1; imem.rdata = 32'hDEAD_BEEF;
        step();
        imem.rvalid = 1'b0; imem.rdata = 32'h0;
        total++; if (misalign_o !== 1'b1 || imem.req !== 1'b0) begin bad++; $display("FAIL mis_after_drain got=m%b r%b want=m1 r0", misalign_o, imem.req); end
        next_pc = 32'h0000_0200; redirect = 1'b1;
        step();
        redirect = 1'b0;
        total++; if (misalign_o !== 1'b0 || imem.req !== 1'b1 || imem.addr !== 32'h200) begin bad++; $display("FAIL mis_recover got=m%b r%b a%h want=m0 r1 a200", misalign_o, imem.req, imem.addr); end
    endtask

    task automatic test_wrap_reset();
        next_pc = 32'hFFFF_FFFC; redirect = 1'b1;
        step();
        redirect = 1'b0;
        total++; if (imem.req !== 1'b1 || imem.addr !== 32'hFFFF_FFFC || pc_add_o !== 32'h0) begin bad++; $display("FAIL wrap_addr got=r%b a%h +%h want=r1 afffffffc +0", imem.req, imem.addr, pc_add_o); end
        fetch_word(32'hCAFE_0013);
        step();
        total++; if (pc_o !== 32'h0 || imem.req !== 1'b1 || imem.addr !== 32'h0 || misalign_o !== 1'b0) begin bad++; $display("FAIL wrap_next got=p%h r%b a%h m%b want=p0 r1 a0 m0", pc_o, imem.req, imem.addr, misalign_o); end
        fetch_word(32'h0000_0093);
        step();
        imem.gnt = 1'b1;
        step();
        imem.gnt = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (pc_o !== RESET_PC || inst_valid_o !== 1'b0 || imem.req !== 1'b0 || inst_o !== NOP) begin bad++; $display("FAIL midop_reset got=p%h v%b r%b i%h want=p%h v0 r0 i%h", pc_o, inst_valid_o, imem.req, inst_o, RESET_PC, NOP); end
        imem.rvalid = 1'b1; imem.rdata = 32'hBAD0_BAD0;
        step();
        imem.rvalid = 1'b0; imem.rdata = 32'h0;
        total++; if (imem.req !== 1'b1 || inst_valid_o !== 1'b0 || inst_o !== NOP) begin bad++; $display("FAIL reset_ignore_rvalid got=r%b v%b i%h want=r1 v0 i%h", imem.req, inst_valid_o, inst_o, NOP); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] mem_addr;
        logic [31:0] tmp;
        logic        pending;
        logic        exp_mis;
        int          delay;
        int          consumed;
        rst = 1'b1; redirect = 1'b0; stall = 1'b0;
        imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'h0;
        step(); step();
        rst = 1'b0;
        exp_pc = RESET_PC; pending = 1'b0; mem_addr = 32'h0; delay = 0; consumed = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            exp_mis = (exp_pc[1:0] != 2'b00) && !pending;
            total++; if (pc_o !== exp_pc || pc_add_o !== exp_pc + 32'd4) begin bad++; $display("FAIL rnd_pc cyc=%0d got=%h/%h want=%h", cyc, pc_o, pc_add_o, exp_pc); end
            total++; if (misalign_o !== exp_mis) begin bad++; $display("FAIL rnd_misalign cyc=%0d got=%b want=%b", cyc, misalign_o, exp_mis); end
            if (imem.req === 1'b1) begin
                total++; if (pending || imem.addr !== exp_pc) begin bad++; $display("FAIL rnd_req cyc=%0d got=a%h pend%b want=a%h pend0", cyc, imem.addr, pending, exp_pc); end
            end
            if (inst_valid_o === 1'b1) begin
                total++; if (pending || inst_o !== inst_at(exp_pc)) begin bad++; $display("FAIL rnd_inst cyc=%0d got=%h pend%b want=%h pend0", cyc, inst_o, pending, inst_at(exp_pc)); end
            end
            if (misalign_o === 1'b1) begin
                total++; if (imem.req !== 1'b0 || inst_valid_o !== 1'b0) begin bad++; $display("FAIL rnd_fault_quiet cyc=%0d got=r%b v%b want=r0 v0", cyc, imem.req, inst_valid_o); end
            end

            // Choose this cycle's inputs.
            redirect = ($urandom_range(0, 11) == 0);
            tmp = $urandom;
            case ($urandom_range(0, 7))
                0:       next_pc = tmp | 32'h0000_0002;
                1:       next_pc = 32'hFFFF_FFF8 + (tmp & 32'h4);
                default: next_pc = tmp & 32'hFFFF_FFFC;
            endcase
            stall    = ($urandom_range(0, 2) == 0);
            imem.gnt = (imem.req === 1'b1) && !pending && ($urandom_range(0, 1) == 1);
            if (pending && delay == 0) begin
                imem.rvalid = 1'b1;
                imem.rdata  = inst_at(mem_addr);
            end else begin
                imem.rvalid = 1'b0;
                imem.rdata  = $urandom;
            end

            // Advance the model across the coming edge.
            if (imem.rvalid) pending = 1'b0;
            else if (pending) delay--;
            if (imem.gnt) begin
                pending  = 1'b1;
                mem_addr = imem.addr;
                delay    = $urandom_range(0, 2);
            end
            if (redirect) begin
                exp_pc = next_pc;
            end else if (inst_valid_o === 1'b1 && !stall) begin
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            step();
        end
        redirect = 1'b0; imem.gnt = 1'b0; imem.rvalid = 1'b0;
        total++; if (consumed < 100) begin bad++; $display("FAIL rnd_progress got=%0d want>=100", consumed); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_hold();
        test_redirect_wait();
        test_misalign();
        test_wrap_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
